// File: rtl/smart_house_uart_rx_pkg.sv
// Shared SmartHouse definitions: receiver FSM encodings, command characters
// and the default UART bit period.
package smart_house_uart_rx_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    HUNT  = 3'd0,
    IDLE  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4,
    BREAK = 3'd5
  } rx_state_t;

  // Letters the controller's command matcher looks for ("OPENWINDOW", ...).
  localparam logic [7:0] ASCII_O = 8'h4F;
  localparam logic [7:0] ASCII_P = 8'h50;
  localparam logic [7:0] ASCII_E = 8'h45;
  localparam logic [7:0] ASCII_N = 8'h4E;
  localparam logic [7:0] ASCII_W = 8'h57;
  localparam logic [7:0] ASCII_I = 8'h49;
  localparam logic [7:0] ASCII_D = 8'h44;

endpackage

// File: rtl/smart_house_sync2.sv
// Two-flop synchroniser for asynchronous SmartHouse inputs; both flops
// reset to RESET_VALUE so an idle line reads idle straight out of reset.
module smart_house_sync2 #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/smart_house_uart_rx.sv
// 8N1 UART receiver feeding the SmartHouse controller: one character per
// strobe cycle on char_req, 8'h00 at all other times.
module smart_house_uart_rx
  import smart_house_uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] char_req,
  output logic       char_valid,
  output logic       frame_error,
  output logic       busy
);

  generate
    if ((CLKS_PER_BIT < 4) || ((CLKS_PER_BIT % 2) != 0)) begin : g_bad_clks_per_bit
      $error("smart_house_uart_rx: CLKS_PER_BIT must be even and >= 4");
    end
  endgenerate

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic          rxs;
  rx_state_t     state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    bit_idx, bit_idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic [7:0]    char_next;
  logic          valid_next, ferr_next;

  smart_house_sync2 #(.RESET_VALUE(1'b1)) u_rx_sync (
    .clock (clock),
    .reset (reset),
    .d     (rx),
    .q     (rxs)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= HUNT;
      cnt         <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      char_req    <= 8'h00;
      char_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      bit_idx     <= bit_idx_next;
      shift_reg   <= shift_next;
      char_req    <= char_next;
      char_valid  <= valid_next;
      frame_error <= ferr_next;
    end
  end

  // Start bit is re-checked at its midpoint; data and stop bits are then
  // sampled one full bit period apart, landing near each bit's centre.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift_reg;
    char_next    = 8'h00;
    valid_next   = 1'b0;
    ferr_next    = 1'b0;
    case (state)
      HUNT: begin
        if (rxs) state_next = IDLE;
      end
      IDLE: begin
        if (!rxs) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_next     = '0;
          bit_idx_next = 3'd0;
          state_next   = rxs ? IDLE : DATA;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_next   = '0;
          shift_next = {rxs, shift_reg[7:1]};
          if (bit_idx == 3'd7) state_next = STOP;
          else                 bit_idx_next = bit_idx + 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_next = '0;
          if (rxs) begin
            char_next  = shift_reg;
            valid_next = 1'b1;
            state_next = IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = BREAK;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      BREAK: begin
        if (rxs) state_next = IDLE;
      end
      default: state_next = HUNT;
    endcase
  end

  assign busy = (state != HUNT) && (state != IDLE);

endmodule

// File: tb/tb_smart_house_uart_rx.sv
// Directed bench for smart_house_uart_rx at CLKS_PER_BIT=4, 20 ns clock:
// strobe timing, back-to-back text, glitch, framing error and mid-frame reset.
module tb_smart_house_uart_rx;

  localparam int CPB = 4;

  logic       clock;
  logic       reset;
  logic       rx;
  logic [7:0] char_req;
  logic       char_valid;
  logic       frame_error;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  int bad_req  = 0;
  int both_hi  = 0;

  logic [7:0] got_char[$];
  int         got_edge[$];
  int         fe_edge[$];

  smart_house_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clock       (clock),
    .reset       (reset),
    .rx          (rx),
    .char_req    (char_req),
    .char_valid  (char_valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  initial begin
    clock = 1'b1;
    forever #10 clock = ~clock;
  end

  always @(posedge clock) edge_cnt++;

  // Strobe log, sampled mid-cycle; edge_cnt here is the edge that launched them.
  always @(negedge clock) begin
    if (char_valid === 1'b1) begin
      got_char.push_back(char_req);
      got_edge.push_back(edge_cnt);
    end
    if (frame_error === 1'b1) fe_edge.push_back(edge_cnt);
    if (char_valid !== 1'b1 && char_req !== 8'h00) bad_req++;
    if (char_valid === 1'b1 && frame_error === 1'b1) both_hi++;
  end

  task automatic clear_log();
    got_char.delete();
    got_edge.delete();
    fe_edge.delete();
  endtask

  // Called at a negedge; e0 is the first edge that samples the start bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int e0);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    e0 = edge_cnt + 1;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (CPB) @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx    = 1'b1;
    #15;
    n_checks++;
    if ({char_req, char_valid, frame_error, busy} !== 11'h000) begin
      n_fail++;
      $display("[TB] FAIL reset_values: got req=%h v=%b fe=%b busy=%b, want all 0", char_req, char_valid, frame_error, busy);
    end
    #15 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      n_checks++;
      if ({char_req, char_valid, frame_error, busy} !== 11'h000) begin
        n_fail++;
        $display("[TB] FAIL idle_outputs cycle %0d: got req=%h v=%b fe=%b busy=%b, want all 0", i, char_req, char_valid, frame_error, busy);
      end
    end
  endtask

  task automatic test_single_char();
    int e0;
    clear_log();
    send_frame(8'h4F, 1'b1, e0);
    repeat (3) @(negedge clock);
    #1;
    n_checks++;
    if (got_char.size() !== 1) begin
      n_fail++;
      $display("[TB] FAIL single_count: got %0d strobes, want 1", got_char.size());
    end else begin
      n_checks++;
      if (got_char[0] !== 8'h4F) begin
        n_fail++;
        $display("[TB] FAIL single_char: got %h, want 4f", got_char[0]);
      end
      n_checks++;
      if (got_edge[0] !== e0 + 40) begin
        n_fail++;
        $display("[TB] FAIL single_latency: strobe after edge %0d, want %0d", got_edge[0], e0 + 40);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] word [10];
    int e0, e_first;
    word = '{8'h4F, 8'h50, 8'h45, 8'h4E, 8'h57, 8'h49, 8'h4E, 8'h44, 8'h4F, 8'h57};
    clear_log();
    e_first = 0;
    for (int k = 0; k < 10; k++) begin
      send_frame(word[k], 1'b1, e0);
      if (k == 0) e_first = e0;
    end
    repeat (3) @(negedge clock);
    #1;
    n_checks++;
    if (got_char.size() !== 10) begin
      n_fail++;
      $display("[TB] FAIL b2b_count: got %0d strobes, want 10", got_char.size());
    end
    for (int k = 0; k < 10 && k < got_char.size(); k++) begin
      n_checks++;
      if (got_char[k] !== word[k] || got_edge[k] !== e_first + 40 + 40 * k) begin
        n_fail++;
        $display("[TB] FAIL b2b_char%0d: got %h at edge %0d, want %h at edge %0d", k, got_char[k], got_edge[k], word[k], e_first + 40 + 40 * k);
      end
    end
  endtask

  task automatic test_glitch();
    clear_log();
    repeat (4) @(negedge clock);
    rx = 1'b0;
    @(negedge clock);
    rx = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL glitch_start: busy=%b, want 1 while checking start bit", busy);
    end
    repeat (3) @(negedge clock);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL glitch_reject: busy=%b, want 0 after rejected start", busy);
    end
    repeat (50) @(negedge clock);
    #1;
    n_checks++;
    if (got_char.size() !== 0 || fe_edge.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL glitch_strobes: got %0d chars %0d errors, want 0 0", got_char.size(), fe_edge.size());
    end
  endtask

  task automatic test_frame_error();
    int e0;
    clear_log();
    send_frame(8'h41, 1'b0, e0);
    repeat (96) @(negedge clock);
    #1;
    n_checks++;
    if (fe_edge.size() !== 1) begin
      n_fail++;
      $display("[TB] FAIL ferr_count: got %0d pulses, want 1", fe_edge.size());
    end else begin
      n_checks++;
      if (fe_edge[0] !== e0 + 40) begin
        n_fail++;
        $display("[TB] FAIL ferr_timing: pulse after edge %0d, want %0d", fe_edge[0], e0 + 40);
      end
    end
    n_checks++;
    if (got_char.size() !== 0 || busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL ferr_break: got %0d chars busy=%b, want 0 chars busy=1", got_char.size(), busy);
    end
    rx = 1'b1;
    repeat (4) @(negedge clock);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL ferr_recover: busy=%b, want 0", busy);
    end
    send_frame(8'h42, 1'b1, e0);
    repeat (3) @(negedge clock);
    #1;
    n_checks++;
    if (got_char.size() !== 1 || (got_char.size() == 1 && (got_char[0] !== 8'h42 || got_edge[0] !== e0 + 40))) begin
      n_fail++;
      $display("[TB] FAIL ferr_next_frame: got %0d strobes first=%h, want 1 strobe 42 at edge %0d", got_char.size(), (got_char.size() > 0) ? got_char[0] : 8'hxx, e0 + 40);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] bits;
    int e0;
    clear_log();
    repeat (4) @(negedge clock);
    bits = {1'b1, 8'hF0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      rx = bits[i];
      repeat (CPB) @(negedge clock);
    end
    rx = bits[4];
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({char_req, char_valid, frame_error, busy} !== 11'h000) begin
      n_fail++;
      $display("[TB] FAIL reset_async: got req=%h v=%b fe=%b busy=%b, want all 0", char_req, char_valid, frame_error, busy);
    end
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    for (int i = 5; i < 10; i++) begin
      rx = bits[i];
      repeat (CPB) @(negedge clock);
    end
    repeat (40) @(negedge clock);
    #1;
    n_checks++;
    if (got_char.size() !== 0 || fe_edge.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL reset_no_partial: got %0d chars %0d errors, want 0 0", got_char.size(), fe_edge.size());
    end
    send_frame(8'h57, 1'b1, e0);
    repeat (3) @(negedge clock);
    #1;
    n_checks++;
    if (got_char.size() !== 1 || (got_char.size() == 1 && (got_char[0] !== 8'h57 || got_edge[0] !== e0 + 40))) begin
      n_fail++;
      $display("[TB] FAIL reset_next_frame: got %0d strobes first=%h, want 1 strobe 57 at edge %0d", got_char.size(), (got_char.size() > 0) ? got_char[0] : 8'hxx, e0 + 40);
    end
  endtask

  task automatic test_output_hygiene();
    n_checks++;
    if (bad_req !== 0) begin
      n_fail++;
      $display("[TB] FAIL req_outside_valid: got %0d cycles, want 0", bad_req);
    end
    n_checks++;
    if (both_hi !== 0) begin
      n_fail++;
      $display("[TB] FAIL valid_and_error: got %0d cycles, want 0", both_hi);
    end
  endtask

  initial begin
    test_reset();
    test_single_char();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
    test_output_hygiene();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
